// File: rtl/puzzle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | puzzle_pkg                                                           |
// | Shared types and constants for the 2x3 sliding-puzzle move control. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package puzzle_pkg;

   localparam int CELL_W  = 3;
   localparam int NCELL   = 6;
   localparam int BOARD_W = CELL_W * NCELL;

   localparam logic [BOARD_W-1:0] SOLVED_BOARD = 18'b001_010_011_100_101_000;

   localparam int REG_BOARD = 0;
   localparam int REG_CNT   = 1;
   localparam int REG_ORD   = 2;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_EDGE    = 2'b01,
      ERR_NOBLANK = 2'b10,
      ERR_EMPTY   = 2'b11
   } err_t;

endpackage
`default_nettype wire

// File: rtl/puzzle_move_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | puzzle_move_calc                                                     |
// | Locates the blank, checks move legality and builds the swapped board.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module puzzle_move_calc
   import puzzle_pkg::*;
(
   input  logic [BOARD_W-1:0] board,
   input  dir_t               dir,
   output logic [2:0]         blank,
   output logic               legal,
   output logic               no_blank,
   output logic [BOARD_W-1:0] new_board
);

   logic [CELL_W-1:0] w_cell [NCELL];
   logic [CELL_W-1:0] w_tile;
   logic [2:0]        w_tgt;

   always_comb begin
      no_blank = 1'b1;
      blank    = 3'd0;
      // Scan downward so the lowest-index blank wins.
      for (int i = NCELL-1; i >= 0; i--) begin
         w_cell[i] = board[BOARD_W-1-CELL_W*i -: CELL_W];
         if (w_cell[i] == '0) begin
            no_blank = 1'b0;
            blank    = 3'(i);
         end
      end

      legal = 1'b0;
      w_tgt = blank;
      if (!no_blank) begin
         case (dir)
            DIR_UP:    if (blank >= 3'd3)          begin legal = 1'b1; w_tgt = blank - 3'd3; end
            DIR_DOWN:  if (blank <= 3'd2)          begin legal = 1'b1; w_tgt = blank + 3'd3; end
            DIR_LEFT:  if ((blank % 3'd3) != 3'd0) begin legal = 1'b1; w_tgt = blank - 3'd1; end
            DIR_RIGHT: if ((blank % 3'd3) != 3'd2) begin legal = 1'b1; w_tgt = blank + 3'd1; end
            default:   legal = 1'b0;
         endcase
      end

      w_tile = '0;
      for (int i = 0; i < NCELL; i++) begin
         if (3'(i) == w_tgt) w_tile = w_cell[i];
      end

      new_board = board;
      if (legal) begin
         for (int i = 0; i < NCELL; i++) begin
            if (3'(i) == blank)
               new_board[BOARD_W-1-CELL_W*i -: CELL_W] = w_tile;
            else if (3'(i) == w_tgt)
               new_board[BOARD_W-1-CELL_W*i -: CELL_W] = '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/puzzle_move_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | puzzle_move_ctrl                                                     |
// | Move sequencer: read board/count/history, check, write back.         |
// | Optional undo support enabled by defining MOVE_UNDO_EN.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module puzzle_move_ctrl #(
   parameter int DATA_W    = 40,
   parameter int ADDR_W    = 4,
   parameter int REG_BOARD = puzzle_pkg::REG_BOARD,
   parameter int REG_CNT   = puzzle_pkg::REG_CNT,
   parameter int REG_ORD   = puzzle_pkg::REG_ORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mv_valid,
   output logic              mv_ready,
   input  logic [1:0]        mv_dir,
   input  logic              mv_undo,
   output logic              done,
   output logic [1:0]        err,
   output logic              solved,
   output logic [ADDR_W-1:0] rf_src0,
   output logic [ADDR_W-1:0] rf_src1,
   input  logic [DATA_W-1:0] rf_data0,
   input  logic [DATA_W-1:0] rf_data1,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_dst,
   output logic [DATA_W-1:0] rf_data
);
   import puzzle_pkg::*;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_RD1  = 3'd2,
      S_CALC = 3'd3,
      S_WB   = 3'd4,
      S_WC   = 3'd5,
      S_WO   = 3'd6,
      S_RESP = 3'd7
   } state_t;

   state_t             r_state;
   dir_t               r_dir;
   err_t               r_err;
   logic [BOARD_W-1:0] r_board;
   logic [BOARD_W-1:0] r_new_board;
   logic [DATA_W-1:0]  r_cnt;
   logic [DATA_W-1:0]  r_ord;

   logic               w_is_undo;
   logic               w_undo_empty;
   dir_t               w_dir;
   logic [2:0]         w_blank;
   logic               w_legal;
   logic               w_no_blank;
   logic [BOARD_W-1:0] w_new_board;
   logic [DATA_W-1:0]  w_cnt_next;
   logic [DATA_W-1:0]  w_ord_next;

`ifdef MOVE_UNDO_EN
   logic r_undo;
   assign w_is_undo = r_undo;
`else
   assign w_is_undo = 1'b0;
`endif

   // Undo replays the inverse of the most recent move.
   assign w_dir        = w_is_undo ? dir_t'(r_ord[1:0] ^ 2'b01) : r_dir;
   assign w_undo_empty = w_is_undo && (r_cnt == '0);
   assign w_cnt_next   = w_is_undo ? r_cnt - 1'b1
                                   : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
   assign w_ord_next   = w_is_undo ? (r_ord >> 2) : {r_ord[DATA_W-3:0], w_dir};

   puzzle_move_calc u_calc (
      .board     (r_board),
      .dir       (w_dir),
      .blank     (w_blank),
      .legal     (w_legal),
      .no_blank  (w_no_blank),
      .new_board (w_new_board)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_dir       <= DIR_UP;
         r_err       <= ERR_OK;
         r_board     <= '0;
         r_new_board <= '0;
         r_cnt       <= '0;
         r_ord       <= '0;
`ifdef MOVE_UNDO_EN
         r_undo      <= 1'b0;
`endif
         mv_ready    <= 1'b1;
         done        <= 1'b0;
         err         <= 2'b00;
         solved      <= 1'b1;
         rf_src0     <= '0;
         rf_src1     <= '0;
         rf_we       <= 1'b0;
         rf_dst      <= '0;
         rf_data     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (mv_valid && mv_ready) begin
                  r_dir    <= dir_t'(mv_dir);
`ifdef MOVE_UNDO_EN
                  r_undo   <= mv_undo;
`endif
                  mv_ready <= 1'b0;
                  rf_src0  <= ADDR_W'(REG_BOARD);
                  rf_src1  <= ADDR_W'(REG_CNT);
                  r_state  <= S_RD0;
               end
            end
            S_RD0: begin
               r_board <= rf_data0[BOARD_W-1:0];
               r_cnt   <= rf_data1;
               rf_src0 <= ADDR_W'(REG_ORD);
               r_state <= S_RD1;
            end
            S_RD1: begin
               r_ord   <= rf_data0;
               r_state <= S_CALC;
            end
            S_CALC: begin
               r_new_board <= w_new_board;
               if (w_undo_empty) begin
                  r_err   <= ERR_EMPTY;
                  r_state <= S_RESP;
               end else if (w_no_blank) begin
                  r_err   <= ERR_NOBLANK;
                  r_state <= S_RESP;
               end else if (!w_legal) begin
                  r_err   <= ERR_EDGE;
                  r_state <= S_RESP;
               end else begin
                  r_err   <= ERR_OK;
                  rf_we   <= 1'b1;
                  rf_dst  <= ADDR_W'(REG_BOARD);
                  rf_data <= {{(DATA_W-BOARD_W){1'b0}}, w_new_board};
                  r_state <= S_WB;
               end
            end
            S_WB: begin
               rf_dst  <= ADDR_W'(REG_CNT);
               rf_data <= w_cnt_next;
               r_state <= S_WC;
            end
            S_WC: begin
               rf_dst  <= ADDR_W'(REG_ORD);
               rf_data <= w_ord_next;
               r_state <= S_WO;
            end
            S_WO: begin
               rf_we   <= 1'b0;
               r_state <= S_RESP;
            end
            S_RESP: begin
               done     <= 1'b1;
               err      <= r_err;
               mv_ready <= 1'b1;
               if (r_err == ERR_OK) solved <= (r_new_board == SOLVED_BOARD);
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_puzzle_move_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_puzzle_move_ctrl                                                  |
// | Directed self-checking bench with a behavioural register file.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_puzzle_move_ctrl;

   localparam logic [1:0]  UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;
   localparam logic [17:0] B_SOLVED = 18'b001_010_011_100_101_000;
   localparam logic [17:0] B_LEFT   = 18'b001_010_011_100_000_101;
   localparam logic [17:0] B_UP     = 18'b001_010_000_100_101_011;
   localparam logic [17:0] B_FULL   = 18'b001_010_011_100_101_110;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mv_valid, mv_ready, mv_undo, done, solved, rf_we;
   logic [1:0]  mv_dir, err;
   logic [3:0]  rf_src0, rf_src1, rf_dst;
   logic [39:0] rf_data0, rf_data1, rf_data;

   logic [39:0] rf [16];
   logic        pk_en;
   logic [3:0]  pk_addr;
   logic [39:0] pk_val;
   int          we_cnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   puzzle_move_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_dir(mv_dir), .mv_undo(mv_undo),
      .done(done), .err(err), .solved(solved),
      .rf_src0(rf_src0), .rf_src1(rf_src1), .rf_data0(rf_data0), .rf_data1(rf_data1),
      .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data)
   );

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
         rf[0] <= {22'b0, B_SOLVED};
      end else if (rf_we) begin
         rf[rf_dst] <= rf_data;
      end else if (pk_en) begin
         rf[pk_addr] <= pk_val;
      end
   end
   assign rf_data0 = rf[rf_src0];
   assign rf_data1 = rf[rf_src1];

   always @(posedge clk) if (rf_we) we_cnt <= we_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic poke(input logic [3:0] addr, input logic [39:0] val);
      @(negedge clk);
      pk_en = 1'b1; pk_addr = addr; pk_val = val;
      @(posedge clk);
      @(negedge clk);
      pk_en = 1'b0;
   endtask

   // Issue one request from a falling edge and time done from the accept edge.
   task automatic do_move(input string tag, input logic [1:0] dir, input logic undo,
                          input int exp_lat, input logic [1:0] exp_err, input int exp_we,
                          input bit busy_poke);
      int lat;
      int we0;
      we0 = we_cnt;
      mv_dir = dir; mv_undo = undo; mv_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mv_valid = 1'b0; mv_dir = ~dir; mv_undo = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (lat == 3) chk({tag, "_busy_ready"}, mv_ready, 1'b0);
         if (busy_poke && lat == 2) begin mv_valid = 1'b1; mv_dir = UP; end
         if (busy_poke && lat == 3) mv_valid = 1'b0;
         if (done) break;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_writes"}, we_cnt - we0, exp_we);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; mv_valid = 1'b0; mv_dir = 2'b00; mv_undo = 1'b0;
      pk_en = 1'b0; pk_addr = '0; pk_val = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      chk("rst_ready", mv_ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 2'b00);
      chk("rst_solved", solved, 1'b1);
      chk("rst_we", rf_we, 1'b0);
      chk("rst_addrs", {rf_src0, rf_src1, rf_dst}, 12'h000);
      chk("rst_wdata", rf_data, 40'h0);

      do_move("left", LEFT, 1'b0, 7, 2'b00, 3, 1'b0);
      chk("left_board", rf[0], {22'b0, B_LEFT});
      chk("left_cnt", rf[1], 40'd1);
      chk("left_ord", rf[2], 40'h2);
      chk("left_solved", solved, 1'b0);

      do_move("right", RIGHT, 1'b0, 7, 2'b00, 3, 1'b0);
      chk("right_board", rf[0], {22'b0, B_SOLVED});
      chk("right_cnt", rf[1], 40'd2);
      chk("right_ord", rf[2], 40'hB);
      chk("right_solved", solved, 1'b1);

      apply_reset();
      do_move("down_edge", DOWN, 1'b0, 4, 2'b01, 0, 1'b0);
      chk("down_edge_cnt", rf[1], 40'd0);
      chk("down_edge_solved", solved, 1'b1);
      do_move("right_edge", RIGHT, 1'b0, 4, 2'b01, 0, 1'b0);
      do_move("up", UP, 1'b0, 7, 2'b00, 3, 1'b0);
      chk("up_board", rf[0], {22'b0, B_UP});
      chk("up_ord", rf[2], 40'h0);
      chk("up_solved", solved, 1'b0);
      do_move("down", DOWN, 1'b0, 7, 2'b00, 3, 1'b0);
      chk("down_board", rf[0], {22'b0, B_SOLVED});
      chk("down_ord", rf[2], 40'h1);
      chk("down_solved", solved, 1'b1);

      apply_reset();
      for (int i = 0; i < 21; i++)
         do_move("seq", (i % 2 == 0) ? LEFT : RIGHT, 1'b0, 7, 2'b00, 3, (i == 3));
      chk("seq_cnt", rf[1], 40'd21);
      chk("seq_ord", rf[2], 40'hEE_EEEE_EEEE);
      chk("seq_board", rf[0], {22'b0, B_LEFT});
      chk("seq_solved", solved, 1'b0);

      apply_reset();
      poke(4'd0, {22'b0, B_FULL});
      do_move("noblank", LEFT, 1'b0, 4, 2'b10, 0, 1'b0);
      chk("noblank_solved", solved, 1'b1);
      chk("noblank_board", rf[0], {22'b0, B_FULL});

      apply_reset();
      poke(4'd1, {40{1'b1}});
      do_move("sat", LEFT, 1'b0, 7, 2'b00, 3, 1'b0);
      chk("sat_cnt", rf[1], {40{1'b1}});
      chk("sat_ord", rf[2], 40'h2);

`ifdef MOVE_UNDO_EN
      do_move("sat_undo", UP, 1'b1, 7, 2'b00, 3, 1'b0);
      chk("sat_undo_cnt", rf[1], {{39{1'b1}}, 1'b0});
      chk("sat_undo_board", rf[0], {22'b0, B_SOLVED});

      apply_reset();
      do_move("u_left", LEFT, 1'b0, 7, 2'b00, 3, 1'b0);
      do_move("undo", UP, 1'b1, 7, 2'b00, 3, 1'b0);
      chk("undo_board", rf[0], {22'b0, B_SOLVED});
      chk("undo_cnt", rf[1], 40'd0);
      chk("undo_ord", rf[2], 40'd0);
      chk("undo_solved", solved, 1'b1);
      do_move("undo_empty", UP, 1'b1, 4, 2'b11, 0, 1'b0);
      chk("undo_empty_cnt", rf[1], 40'd0);
`else
      apply_reset();
      do_move("undo_ignored", LEFT, 1'b1, 7, 2'b00, 3, 1'b0);
      chk("undo_ignored_board", rf[0], {22'b0, B_LEFT});
      chk("undo_ignored_cnt", rf[1], 40'd1);
      chk("undo_ignored_ord", rf[2], 40'h2);
`endif

      // Reset while the count write is on the bus.
      apply_reset();
      mv_dir = LEFT; mv_undo = 1'b0; mv_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mv_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("wc_we", rf_we, 1'b1);
      chk("wc_dst", rf_dst, 4'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_ready", mv_ready, 1'b1);
      chk("midrst_done", done, 1'b0);
      chk("midrst_solved", solved, 1'b1);
      chk("midrst_we", rf_we, 1'b0);
      rst_n = 1'b1;
      do_move("post_rst", LEFT, 1'b0, 7, 2'b00, 3, 1'b0);
      chk("post_rst_cnt", rf[1], 40'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
